// File: rtl/missile_alert_filter.sv
// missile_alert_filter
// Sliding-window vote over classifier decisions with hysteresis and a
// cooldown hold. The window popcount drives a four-state FSM whose
// ALERT/COOL states form one alert episode. Within an episode the block
// records the highest classifier score it has seen. All outputs are
// registered. rst_n clears everything asynchronously. clear flushes the
// same state on the next clock edge.
module missile_alert_filter #(
    parameter int WIN   = 8,
    parameter int K_ON  = 5,
    parameter int K_OFF = 2,
    parameter int HOLD  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dec_valid,
    input  logic               is_missile,
    input  logic signed [31:0] sum,
    input  logic               clear,
    output logic               alert,
    output logic               alert_rise,
    output logic [4:0]         hit_count,
    output logic signed [31:0] peak_score,
    output logic [15:0]        frame_count,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ALERT = 2'd2,
        ST_COOL  = 2'd3
    } state_t;

    localparam logic [4:0]  K_ON_C  = 5'(K_ON);
    localparam logic [4:0]  K_OFF_C = 5'(K_OFF);
    localparam logic [7:0]  HOLD_C  = 8'(HOLD);
    localparam logic [15:0] FRAME_MAX = 16'hFFFF;

    // Number of set bits in a window snapshot (WIN <= 16 fits in 5 bits).
    function automatic logic [4:0] popcount(input logic [WIN-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < WIN; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Registered state
    logic [WIN-1:0]     hist_r;
    logic [4:0]         hit_r;
    state_t             state_r;
    logic [7:0]         hold_r;
    logic signed [31:0] peak_r;
    logic [15:0]        frame_r;
    logic               alert_r;
    logic               rise_r;

    // Next-state values
    logic [WIN-1:0]     hist_s;
    logic [WIN-1:0]     hist_shift_s;
    logic [4:0]         hit_s;
    logic [4:0]         h_s;
    state_t             state_s;
    logic [7:0]         hold_s;
    logic signed [31:0] peak_s;
    logic [15:0]        frame_s;
    logic               alert_s;
    logic               rise_s;

    // Window after accepting the presented decision, and its popcount.
    always_comb begin
        hist_shift_s = {hist_r[WIN-2:0], is_missile};
        h_s          = popcount(hist_shift_s);
    end

    // Next-state logic: clear wins over a decision; the FSM only moves when
    // a decision is accepted, and it uses that decision's updated popcount.
    always_comb begin
        hist_s  = hist_r;
        hit_s   = hit_r;
        state_s = state_r;
        hold_s  = hold_r;
        peak_s  = peak_r;
        frame_s = frame_r;
        rise_s  = 1'b0;

        if (clear) begin
            hist_s  = '0;
            hit_s   = 5'd0;
            state_s = ST_IDLE;
            hold_s  = 8'd0;
            peak_s  = 32'sd0;
            frame_s = 16'd0;
        end else if (dec_valid) begin
            hist_s = hist_shift_s;
            hit_s  = h_s;
            if (frame_r == FRAME_MAX) begin
                frame_s = frame_r;
            end else begin
                frame_s = frame_r + 16'd1;
            end

            case (state_r)
                ST_IDLE, ST_TRACK: begin
                    if (h_s >= K_ON_C) begin
                        // New episode: peak restarts from the triggering score.
                        state_s = ST_ALERT;
                        peak_s  = sum;
                        rise_s  = 1'b1;
                    end else if (h_s != 5'd0) begin
                        state_s = ST_TRACK;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end

                ST_ALERT: begin
                    if (sum > peak_r) begin
                        peak_s = sum;
                    end else begin
                        peak_s = peak_r;
                    end
                    if (h_s < K_OFF_C) begin
                        state_s = ST_COOL;
                        hold_s  = HOLD_C;
                    end else begin
                        state_s = ST_ALERT;
                    end
                end

                ST_COOL: begin
                    if (sum > peak_r) begin
                        peak_s = sum;
                    end else begin
                        peak_s = peak_r;
                    end
                    if (h_s >= K_ON_C) begin
                        // Re-arm inside the same episode: no rise pulse.
                        state_s = ST_ALERT;
                        hold_s  = 8'd0;
                    end else if (hold_r <= 8'd1) begin
                        // This decision takes the hold counter to zero.
                        hold_s = 8'd0;
                        if (h_s != 5'd0) begin
                            state_s = ST_TRACK;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        hold_s = hold_r - 8'd1;
                    end
                end

                default: begin
                    state_s = ST_IDLE;
                    hold_s  = 8'd0;
                end
            endcase
        end else begin
            // No decision this cycle: everything holds except the rise pulse.
            hist_s = hist_r;
        end

        alert_s = (state_s == ST_ALERT) || (state_s == ST_COOL);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r  <= '0;
            hit_r   <= 5'd0;
            state_r <= ST_IDLE;
            hold_r  <= 8'd0;
            peak_r  <= 32'sd0;
            frame_r <= 16'd0;
            alert_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            hist_r  <= hist_s;
            hit_r   <= hit_s;
            state_r <= state_s;
            hold_r  <= hold_s;
            peak_r  <= peak_s;
            frame_r <= frame_s;
            alert_r <= alert_s;
            rise_r  <= rise_s;
        end
    end

    assign alert       = alert_r;
    assign alert_rise  = rise_r;
    assign hit_count   = hit_r;
    assign peak_score  = peak_r;
    assign frame_count = frame_r;
    assign state       = state_r;

endmodule

// File: tb/tb_missile_alert_filter.sv
// Bench for missile_alert_filter. It keeps a behavioural model built on a
// queue of recent decisions and compares all outputs every cycle. It also
// pins the model with hand-derived values at the key points of each scenario.
module tb_missile_alert_filter;

    localparam int WIN   = 8;
    localparam int K_ON  = 5;
    localparam int K_OFF = 2;
    localparam int HOLD  = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               dec_valid;
    logic               is_missile;
    logic signed [31:0] sum;
    logic               clear;
    logic               alert;
    logic               alert_rise;
    logic [4:0]         hit_count;
    logic signed [31:0] peak_score;
    logic [15:0]        frame_count;
    logic [1:0]         state;

    missile_alert_filter #(.WIN(WIN), .K_ON(K_ON), .K_OFF(K_OFF), .HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .is_missile(is_missile),
        .sum(sum), .clear(clear), .alert(alert), .alert_rise(alert_rise),
        .hit_count(hit_count), .peak_score(peak_score), .frame_count(frame_count),
        .state(state)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    // Behavioural model: window as a queue of recent decisions.
    int                 win_q[$];
    int                 m_state;   // 0 idle, 1 tracking, 2 alert, 3 cooling
    int                 m_hold;
    int                 m_frame;
    logic signed [31:0] m_peak;
    bit                 m_rise;

    function automatic int m_hits();
        int n = 0;
        foreach (win_q[i]) n += win_q[i];
        return n;
    endfunction

    task automatic m_reset();
        win_q.delete();
        m_state = 0;
        m_hold  = 0;
        m_frame = 0;
        m_peak  = 0;
        m_rise  = 1'b0;
    endtask

    task automatic m_clock(bit v, bit m, int s, bit c);
        int h;
        m_rise = 1'b0;
        if (c) begin
            m_reset();
        end else if (v) begin
            win_q.push_back(m ? 1 : 0);
            if (win_q.size() > WIN) void'(win_q.pop_front());
            h = m_hits();
            if (m_frame < 65535) m_frame++;
            if (m_state >= 2 && s > m_peak) m_peak = s;
            if (m_state < 2) begin
                if (h >= K_ON) begin
                    m_state = 2;
                    m_peak  = s;
                    m_rise  = 1'b1;
                end else begin
                    m_state = (h > 0) ? 1 : 0;
                end
            end else if (m_state == 2) begin
                if (h < K_OFF) begin
                    m_state = 3;
                    m_hold  = HOLD;
                end
            end else begin
                if (h >= K_ON) begin
                    m_state = 2;
                end else begin
                    m_hold--;
                    if (m_hold == 0) m_state = (h > 0) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("alert",       {31'd0, alert},      (m_state >= 2) ? 32'd1 : 32'd0);
            chk("alert_rise",  {31'd0, alert_rise}, m_rise ? 32'd1 : 32'd0);
            chk("hit_count",   {27'd0, hit_count},  32'(m_hits()));
            chk("peak_score",  peak_score,          m_peak);
            chk("frame_count", {16'd0, frame_count}, 32'(m_frame));
            chk("state",       {30'd0, state},      32'(m_state));
        end
    end

    // One clock cycle of stimulus; the model advances with the DUT edge.
    task automatic step(bit v, bit m, int s, bit c);
        @(negedge clk);
        dec_valid  = v;
        is_missile = m;
        sum        = s;
        clear      = c;
        @(posedge clk);
        m_clock(v, m, s, c);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; dec_valid = 1'b0; is_missile = 1'b0; sum = 0; clear = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_alert", {31'd0, alert}, 32'd0);
        chk("rst_frame", {16'd0, frame_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Five missile decisions raise the alert on the fifth.
        step(1'b1, 1'b1, 10, 1'b0);
        chk("first_state", {30'd0, state}, 32'd1);
        chk("first_hits",  {27'd0, hit_count}, 32'd1);
        step(1'b1, 1'b1, 300, 1'b0);
        step(1'b1, 1'b1, 50, 1'b0);
        step(1'b1, 1'b1, 900, 1'b0);
        chk("pre_alert_state", {30'd0, state}, 32'd1);
        step(1'b1, 1'b1, 20, 1'b0);
        chk("on_state", {30'd0, state}, 32'd2);
        chk("on_hits",  {27'd0, hit_count}, 32'd5);
        chk("on_peak",  peak_score, 32'sd20);
        chk("on_rise",  {31'd0, alert_rise}, 32'd1);
        step(1'b0, 1'b0, 0, 1'b0);
        chk("rise_drop",  {31'd0, alert_rise}, 32'd0);
        chk("idle_hold",  {27'd0, hit_count}, 32'd5);
        chk("idle_frame", {16'd0, frame_count}, 32'd5);

        // Fill the window; peak follows the signed maximum.
        step(1'b1, 1'b1, 5, 1'b0);
        step(1'b1, 1'b1, 40, 1'b0);
        step(1'b1, 1'b1, -7, 1'b0);
        chk("full_hits", {27'd0, hit_count}, 32'd8);
        chk("full_peak", peak_score, 32'sd40);

        // Enter cooling with the lone hit newest, then recover to ALERT.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 1'b0);
        chk("h2_state", {30'd0, state}, 32'd2);
        step(1'b1, 1'b1, 0, 1'b0);
        chk("h2b_hits", {27'd0, hit_count}, 32'd2);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("cool_state", {30'd0, state}, 32'd3);
        chk("cool_hits",  {27'd0, hit_count}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, (i == 3) ? 60 : 0, 1'b0);
            chk("rearm_alert", {31'd0, alert}, 32'd1);
            chk("rearm_rise",  {31'd0, alert_rise}, 32'd0);
        end
        chk("rearm_state", {30'd0, state}, 32'd2);
        chk("rearm_hits",  {27'd0, hit_count}, 32'd5);
        chk("rearm_peak",  peak_score, 32'sd60);

        // All-ones window, then seven zeros to cool and four more to idle.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 0, 1'b0);
        chk("ones_hits", {27'd0, hit_count}, 32'd8);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 1'b0);
        chk("z6_state", {30'd0, state}, 32'd2);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("z7_state", {30'd0, state}, 32'd3);
        chk("z7_hits",  {27'd0, hit_count}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0);
        chk("hold3_state", {30'd0, state}, 32'd3);
        chk("hold3_alert", {31'd0, alert}, 32'd1);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("hold_done_state", {30'd0, state}, 32'd0);
        chk("hold_done_alert", {31'd0, alert}, 32'd0);
        chk("hold_done_peak",  peak_score, 32'sd60);

        // Clear colliding with a decision while in ALERT.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 7, 1'b0);
        chk("re_alert_peak", peak_score, 32'sd7);
        step(1'b1, 1'b1, 100, 1'b1);
        chk("clr_state", {30'd0, state}, 32'd0);
        chk("clr_hits",  {27'd0, hit_count}, 32'd0);
        chk("clr_frame", {16'd0, frame_count}, 32'd0);
        chk("clr_alert", {31'd0, alert}, 32'd0);
        chk("clr_peak",  peak_score, 32'sd0);

        // Saturation of the frame counter under continuous random decisions.
        for (int i = 0; i < 70000; i++)
            step(1'b1, 1'($urandom_range(0, 1)), int'($urandom), 1'b0);
        chk("sat_frame", {16'd0, frame_count}, 32'd65535);
        step(1'b1, 1'b1, 0, 1'b0);
        chk("sat_hold", {16'd0, frame_count}, 32'd65535);

        // Asynchronous reset in the middle of an alert episode.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3, 1'b0);
        chk("pre_rst_state", {30'd0, state}, 32'd2);
        #2;
        rst_n = 1'b0; dec_valid = 1'b0; clear = 1'b0;
        m_reset();
        #1;
        chk("arst_alert", {31'd0, alert}, 32'd0);
        chk("arst_rise",  {31'd0, alert_rise}, 32'd0);
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_hits",  {27'd0, hit_count}, 32'd0);
        chk("arst_frame", {16'd0, frame_count}, 32'd0);
        chk("arst_peak",  peak_score, 32'sd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 33, 1'b0);
        chk("post_rst_state", {30'd0, state}, 32'd1);
        chk("post_rst_hits",  {27'd0, hit_count}, 32'd1);
        chk("post_rst_rise",  {31'd0, alert_rise}, 32'd0);
        chk("post_rst_frame", {16'd0, frame_count}, 32'd1);

        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
